// File: rtl/mdu_sched_if.sv
// ---------------------------------------------------------------------------
// mdu_sched_if
// Groups the E-stage and D-stage connections between the pipeline and the
// multiply/divide scheduler. Clock and reset are not part of this bundle.
//
//   master (pipeline side):
//     mdu_op    -> MDU opcode of the E-stage instruction
//                  (0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo)
//     mdu_start -> E-stage instruction is mult/multu/div/divu
//     e_valid   -> E-stage slot holds a real instruction
//     rs_val    -> forwarded rs operand in E
//     rt_val    -> forwarded rt operand in E
//     d_use_mdu -> D-stage instruction touches the MDU
//     busy      <- unit occupied by a multiply/divide
//     stall_d   <- freeze F/D and inject a bubble into E
//     mdu_rdata <- HI for mfhi, LO for mflo, else 0
//     hi, lo    <- architectural HI/LO
// ---------------------------------------------------------------------------
interface mdu_sched_if;
    logic [4:0]  mdu_op;
    logic        mdu_start;
    logic        e_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_use_mdu;
    logic        busy;
    logic        stall_d;
    logic [31:0] mdu_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output mdu_op, mdu_start, e_valid, rs_val, rt_val, d_use_mdu,
        input  busy, stall_d, mdu_rdata, hi, lo
    );

    modport slave (
        input  mdu_op, mdu_start, e_valid, rs_val, rt_val, d_use_mdu,
        output busy, stall_d, mdu_rdata, hi, lo
    );
endinterface

// File: rtl/mdu_sched.sv
// ---------------------------------------------------------------------------
// mdu_sched
// Sequences the multiply/divide unit in the E stage of the pipelined core.
// A mult/multu/div/divu issued from E computes its 64-bit result at issue
// time, parks it in pending registers, and holds the unit busy for a fixed
// latency; HI/LO are committed on the edge that ends the busy period.
// mthi/mtlo write HI/LO directly while idle; mfhi/mflo read HI/LO
// combinationally. stall_d blocks any D-stage MDU instruction while the
// unit is occupied, including the cycle in which a new operation issues.
//
// Ports:
//   clk    in  core clock, all state updates on the rising edge
//   reset  in  asynchronous, active-low reset
//   bus    slave side of mdu_sched_if (operands, opcode, stall, HI/LO)
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>=1)
//   DIV_CYCLES   busy cycles for div/divu   (>=1)
// ---------------------------------------------------------------------------
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // The counter only ever holds N-1, so clog2(N) bits suffice.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [4:0] OP_MULT  = 5'd0;
    localparam logic [4:0] OP_MULTU = 5'd1;
    localparam logic [4:0] OP_DIV   = 5'd2;
    localparam logic [4:0] OP_DIVU  = 5'd3;
    localparam logic [4:0] OP_MFHI  = 5'd4;
    localparam logic [4:0] OP_MFLO  = 5'd5;
    localparam logic [4:0] OP_MTHI  = 5'd6;
    localparam logic [4:0] OP_MTLO  = 5'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Result computation for the four arithmetic ops.
    // Returns {write_enable, hi, lo}; write_enable is cleared for a division
    // by zero so that HI/LO keep their old contents at completion.
    // -----------------------------------------------------------------------
    function automatic logic [64:0] mdu_result(
        input logic [4:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [63:0] prod_s;
        logic        [63:0] prod_u;
        logic signed [31:0] a_s;
        logic signed [31:0] b_s;
        logic signed [31:0] quo_s;
        logic signed [31:0] rem_s;
        logic        [31:0] b_u;
        logic        [31:0] quo_u;
        logic        [31:0] rem_u;
        logic               div_zero;
        logic               div_ovf;
        logic        [64:0] res;

        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'd0, a} * {32'd0, b};
        div_zero = (b == 32'd0);
        // 0x80000000 / -1 overflows; dividing by +1 instead yields exactly
        // the required quotient 0x80000000 and remainder 0.
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

        a_s   = $signed(a);
        b_s   = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
        quo_s = a_s / b_s;
        rem_s = a_s % b_s;   // sign of remainder follows the dividend

        b_u   = div_zero ? 32'd1 : b;
        quo_u = a / b_u;
        rem_u = a % b_u;

        res = '0;
        case (op)
            OP_MULT:  res = {1'b1, prod_s[63:32], prod_s[31:0]};
            OP_MULTU: res = {1'b1, prod_u[63:32], prod_u[31:0]};
            OP_DIV:   res = {~div_zero, rem_s, quo_s};
            OP_DIVU:  res = {~div_zero, rem_u, quo_u};
            default:  res = '0;
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic [31:0]       hi_q,      hi_d;
    logic [31:0]       lo_q,      lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;

    logic              start_fire;
    logic              op_is_div;
    logic [64:0]       result;

    assign start_fire = bus.mdu_start & bus.e_valid;
    assign op_is_div  = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);
    assign result     = mdu_result(bus.mdu_op, bus.rs_val, bus.rt_val);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            S_IDLE: begin
                if (start_fire) begin
                    state_d   = S_BUSY;
                    busy_d    = 1'b1;
                    cnt_d     = op_is_div ? DIV_LOAD : MULT_LOAD;
                    pend_wr_d = result[64];
                    pend_hi_d = result[63:32];
                    pend_lo_d = result[31:0];
                end else if (bus.e_valid) begin
                    if (bus.mdu_op == OP_MTHI) hi_d = bus.rs_val;
                    if (bus.mdu_op == OP_MTLO) lo_d = bus.rs_val;
                end
            end
            S_BUSY: begin
                // New starts and mt writes are ignored here; stall_d keeps
                // them from arriving in a well-formed pipeline.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers: reset discards any operation in flight
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // The issue cycle itself stalls D so an MDU instruction directly behind
    // a mult/div never reaches E while the unit is (about to be) occupied.
    assign bus.stall_d = bus.d_use_mdu & (busy_q | start_fire);

    // mfhi/mflo see committed HI/LO only; pending results are not forwarded.
    always_comb begin
        case (bus.mdu_op)
            OP_MFHI: bus.mdu_rdata = hi_q;
            OP_MFLO: bus.mdu_rdata = lo_q;
            default: bus.mdu_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_sched.sv
// ---------------------------------------------------------------------------
// tb_mdu_sched
// Directed bench for mdu_sched. Each issued mult/div pushes its expected
// {HI,LO} onto a scoreboard queue; the entry is popped and compared once
// busy falls. Inputs change on the falling edge, outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mdu_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;

    mdu_sched_if bus ();

    mdu_sched #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    int          stall_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: 64-bit longint arithmetic, no overflow special case.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        p  = {model_hi, model_lo};
        case (op)
            5'd0: p = 64'(sa * sb);
            5'd1: p = {32'd0, a} * {32'd0, b};
            5'd2: if (b != 0) begin
                      q = sa / sb;
                      r = sa % sb;
                      p = {r[31:0], q[31:0]};
                  end
            5'd3: if (b != 0) p = {a % b, a / b};
            default: ;
        endcase
        return p;
    endfunction

    // Called on a falling edge; returns on the falling edge after issue.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.mdu_op    = op;
        bus.rs_val    = a;
        bus.rt_val    = b;
        bus.mdu_start = 1'b1;
        bus.e_valid   = 1'b1;
        exp_q.push_back(model(op, a, b));
        #1;
        if (bus.stall_d === 1'b1) stall_cnt++;
        @(negedge clk);
        bus.mdu_start = 1'b0;
        bus.e_valid   = 1'b0;
    endtask

    // Counts busy cycles (bounded), optionally injects a start mid-operation,
    // then compares HI/LO against the scoreboard head.
    task automatic wait_done(input string tag, input int n_exp, input bit inject);
        int cnt;
        logic [63:0] e;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            if (bus.stall_d === 1'b1) stall_cnt++;
            cnt++;
            if (inject && cnt == 2) begin
                bus.mdu_op    = 5'd2;
                bus.rs_val    = 32'd100;
                bus.rt_val    = 32'd3;
                bus.mdu_start = 1'b1;
                bus.e_valid   = 1'b1;
            end else begin
                bus.mdu_start = 1'b0;
                bus.e_valid   = 1'b0;
            end
            @(negedge clk);
        end
        bus.mdu_start = 1'b0;
        bus.e_valid   = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(n_exp));
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            model_hi = e[63:32];
            model_lo = e[31:0];
            check({tag, "_hilo"}, {bus.hi, bus.lo}, e);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.mdu_op    = '0;
        bus.mdu_start = 1'b0;
        bus.e_valid   = 1'b0;
        bus.rs_val    = '0;
        bus.rt_val    = '0;
        bus.d_use_mdu = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1. idle after reset
        check("rst_busy",    64'(bus.busy),    64'd0);
        check("rst_stall",   64'(bus.stall_d), 64'd0);
        check("rst_hilo",    {bus.hi, bus.lo}, 64'd0);
        bus.mdu_op = 5'd4;
        #1;
        check("rst_rdata",   64'(bus.mdu_rdata), 64'd0);
        @(negedge clk);

        // 2. mult / multu
        issue(5'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done("mult", MULT_N, 1'b0);
        check("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(5'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done("multu", MULT_N, 1'b0);
        check("multu_const", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);

        // 3. div / div by zero / overflow / divu
        issue(5'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", DIV_N, 1'b0);
        check("div_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(5'd2, 32'h1234_5678, 32'd0);
        wait_done("div0", DIV_N, 1'b0);
        check("div0_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(5'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", DIV_N, 1'b0);
        check("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        issue(5'd3, 32'hFFFF_FFF9, 32'd7);
        wait_done("divu", DIV_N, 1'b0);

        // 4. mult with an MDU instruction waiting in D, then mflo / mfhi
        bus.d_use_mdu = 1'b1;
        stall_cnt = 0;
        issue(5'd0, 32'h0001_0000, 32'h0003_0005);
        wait_done("mult_stall", MULT_N, 1'b0);
        check("stall_cycles", 64'(stall_cnt), 64'(MULT_N + 1));
        check("stall_after", 64'(bus.stall_d), 64'd0);
        bus.mdu_op = 5'd5;
        #1;
        check("mflo", 64'(bus.mdu_rdata), 64'h0000_0000_0005_0000);
        bus.mdu_op = 5'd4;
        #1;
        check("mfhi", 64'(bus.mdu_rdata), 64'h0000_0000_0000_0003);
        bus.d_use_mdu = 1'b0;
        @(negedge clk);

        // start while busy is ignored
        issue(5'd1, 32'd1000, 32'd1000);
        wait_done("start_busy", MULT_N, 1'b1);
        check("start_busy_after", 64'(bus.busy), 64'd0);

        // 5. mthi / mtlo, and a start without e_valid
        bus.mdu_op  = 5'd6;
        bus.rs_val  = 32'h0000_1234;
        bus.e_valid = 1'b1;
        @(negedge clk);
        check("mthi", 64'(bus.hi), 64'h1234);
        bus.mdu_op  = 5'd7;
        bus.rs_val  = 32'hCAFE_0001;
        @(negedge clk);
        bus.e_valid = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, 64'h0000_1234_CAFE_0001);
        bus.mdu_op    = 5'd0;
        bus.mdu_start = 1'b1;
        @(negedge clk);
        check("start_no_valid_1", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("start_no_valid_2", 64'(bus.busy), 64'd0);
        bus.mdu_start = 1'b0;
        model_hi = 32'h0000_1234;
        model_lo = 32'hCAFE_0001;

        // 6. reset in the middle of a divide
        issue(5'd2, 32'd1000, 32'd7);
        repeat (3) @(negedge clk);
        check("mid_div_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(5'd0, 32'd6, 32'hFFFF_FFF9);
        wait_done("post_rst_mult", MULT_N, 1'b0);
        check("post_rst_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFD6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
